// File: rtl/npu_act_norm.sv
// npu_act_norm: activation + min-max normalisation stage.
//
// Accepts a ROWS x COLS signed matrix as a row-major valid/ready stream, applies a
// run-time-selected activation (bypass, ReLU, leaky ReLU with 2^-shift slope), buffers
// the activated matrix while tracking min/max, then streams every element out
// normalised to OUT_W unsigned bits:
//   out = min(((a - min) * SCALE + RND) >> FRAC, 2^OUT_W - 1)
//   SCALE = floor(((2^OUT_W - 1) << FRAC) / (max - min)), or 0 when max == min.
// SCALE comes from a restoring divider producing one quotient bit per cycle.
//
// Optional build macro: NPU_ACT_NORM_ROUND_EN -- adds 2^(FRAC-1) before the final
// shift (round half up); without it the result is truncated.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   start_i              one-cycle job request, sampled only when idle
//   act_mode_i           00 bypass, 01 ReLU, 10 leaky, 11 bypass (latched at start)
//   leak_shift_i         leaky slope exponent (latched at start)
//   in_valid_i/in_ready_o/in_data_i     input element stream (ready only while loading)
//   out_valid_o/out_ready_i/out_data_o  normalised output stream
//   busy_o               high whenever a job is in progress
//   done_o               one-cycle pulse after the last output handshake
module npu_act_norm #(
  parameter int unsigned ROWS  = 10,
  parameter int unsigned COLS  = 10,
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned FRAC  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       act_mode_i,
  input  logic [3:0]       leak_shift_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned QW = OUT_W + FRAC;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned DW = (QW > 1) ? $clog2(QW) : 1;
  localparam int unsigned PW = IN_W + QW;

  localparam logic [QW-1:0]    Dividend = {{OUT_W{1'b1}}, {FRAC{1'b0}}};
  localparam logic [OUT_W-1:0] MaxOut   = '1;

`ifdef NPU_ACT_NORM_ROUND_EN
  localparam logic [PW:0] Rnd = (PW + 1)'(1) << (FRAC - 1);
`else
  localparam logic [PW:0] Rnd = '0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDiv,
    StPrime,
    StEmit,
    StDone
  } state_e;

  state_e                 state_q;
  logic [1:0]             mode_q;
  logic [3:0]             shift_q;
  logic [AW-1:0]          in_idx_q;
  logic signed [IN_W-1:0] min_q, max_q;
  logic [QW-1:0]          quo_q;
  logic [IN_W-1:0]        rem_q;
  logic [DW-1:0]          div_cnt_q;
  logic [IN_W-1:0]        rd_q;
  logic [CW-1:0]          rd_idx_q;
  logic                   rd_vld_q;
  logic [AW-1:0]          out_cnt_q;
  logic                   in_ready_q, out_valid_q, busy_q, done_q;
  logic [OUT_W-1:0]       out_data_q;

  logic [IN_W-1:0]        mem_q [N];

  // Activation of the element currently on the input bus.
  logic signed [IN_W-1:0] x_in, act;
  assign x_in = signed'(in_data_i);

  always_comb begin
    act = x_in;
    case (mode_q)
      2'b01:   act = x_in[IN_W-1] ? '0 : x_in;
      2'b10:   act = x_in[IN_W-1] ? (x_in >>> shift_q) : x_in;
      default: act = x_in;
    endcase
  end

  logic wr_en;
  assign wr_en = (state_q == StLoad) && in_valid_i;

  // Element buffer; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[in_idx_q] <= act;
    end
  end

  // Range always fits IN_W unsigned bits, so a wrapping subtract is exact.
  logic [IN_W-1:0] range_w;
  assign range_w = max_q - min_q;

  // Restoring division step. The dividend shifts out of quo_q's MSB while quotient bits
  // shift into its LSB. The remainder stays below range_w; when the shifted-in
  // remainder overflows IN_W bits it certainly exceeds range_w.
  logic [IN_W:0]   rem_sh;
  logic            rem_ge;
  logic [IN_W-1:0] rem_nx;
  logic [QW-1:0]   quo_nx;

  assign rem_sh = {rem_q, quo_q[QW-1]};
  assign rem_ge = rem_sh[IN_W] || (rem_sh[IN_W-1:0] >= range_w);
  assign rem_nx = rem_ge ? (rem_sh[IN_W-1:0] - range_w) : rem_sh[IN_W-1:0];
  assign quo_nx = {quo_q[QW-2:0], rem_ge};

  // Normalisation of the buffered element in rd_q; quo_q holds SCALE by now.
  logic [IN_W-1:0]  diff;
  logic [PW:0]      prod, shifted;
  logic [OUT_W-1:0] norm;

  assign diff    = rd_q - min_q;
  assign prod    = (PW + 1)'(diff) * (PW + 1)'(quo_q) + Rnd;
  assign shifted = prod >> FRAC;
  assign norm    = (shifted > (PW + 1)'(MaxOut)) ? MaxOut : shifted[OUT_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      mode_q      <= '0;
      shift_q     <= '0;
      in_idx_q    <= '0;
      min_q       <= '0;
      max_q       <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      div_cnt_q   <= '0;
      rd_q        <= '0;
      rd_idx_q    <= '0;
      rd_vld_q    <= 1'b0;
      out_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            mode_q     <= act_mode_i;
            shift_q    <= leak_shift_i;
            in_idx_q   <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StLoad;
          end
        end

        StLoad: begin
          if (in_valid_i) begin
            if (in_idx_q == '0 || act < min_q) min_q <= act;
            if (in_idx_q == '0 || act > max_q) max_q <= act;
            if (in_idx_q == AW'(N - 1)) begin
              in_ready_q <= 1'b0;
              quo_q      <= Dividend;
              rem_q      <= '0;
              div_cnt_q  <= '0;
              state_q    <= StDiv;
            end else begin
              in_idx_q <= in_idx_q + 1'b1;
            end
          end
        end

        StDiv: begin
          rem_q     <= rem_nx;
          quo_q     <= quo_nx;
          div_cnt_q <= div_cnt_q + 1'b1;
          if (div_cnt_q == DW'(QW - 1)) begin
            // A flat matrix would otherwise yield an all-ones quotient.
            if (range_w == '0) quo_q <= '0;
            state_q <= StPrime;
          end
        end

        StPrime: begin
          rd_q      <= mem_q[0];
          rd_idx_q  <= CW'(1);
          rd_vld_q  <= 1'b1;
          out_cnt_q <= '0;
          state_q   <= StEmit;
        end

        StEmit: begin
          // Output register is free: refill it from rd_q and prefetch the next element.
          if (!out_valid_q || out_ready_i) begin
            if (rd_vld_q) begin
              out_data_q  <= norm;
              out_valid_q <= 1'b1;
              if (rd_idx_q < CW'(N)) begin
                rd_q     <= mem_q[rd_idx_q[AW-1:0]];
                rd_idx_q <= rd_idx_q + 1'b1;
              end else begin
                rd_vld_q <= 1'b0;
              end
            end else begin
              out_valid_q <= 1'b0;
            end
          end
          if (out_valid_q && out_ready_i) begin
            if (out_cnt_q == AW'(N - 1)) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= StDone;
            end else begin
              out_cnt_q <= out_cnt_q + 1'b1;
            end
          end
        end

        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_npu_act_norm.sv
// Testbench for npu_act_norm: a 2x2 instance (index 0) for the hand-computed vectors and
// a default 10x10 instance (index 1) for the long job against a reference model.
// Expected outputs are queued when a job is issued; a monitor pops them on handshakes.
module tb_npu_act_norm;

  localparam int QW   = 24;
  localparam int Frac = 16;
`ifdef NPU_ACT_NORM_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [1:0]       start, in_valid, out_ready;
  logic [1:0][1:0]  mode;
  logic [1:0][3:0]  lsh;
  logic [1:0][15:0] in_data;
  wire  [1:0]       in_ready, out_valid, busy, done;
  wire  [1:0][7:0]  out_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_in [2];
  bit first_seen [2];
  int done_cnt [2];
  bit hold_prev [2];
  logic [7:0] hold_data [2];
  int rdy_mode [2];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic signed [15:0] vec [100];

  npu_act_norm #(.ROWS(2), .COLS(2)) u_small (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start[0]),
    .act_mode_i  (mode[0]),
    .leak_shift_i(lsh[0]),
    .in_valid_i  (in_valid[0]),
    .in_ready_o  (in_ready[0]),
    .in_data_i   (in_data[0]),
    .out_valid_o (out_valid[0]),
    .out_ready_i (out_ready[0]),
    .out_data_o  (out_data[0]),
    .busy_o      (busy[0]),
    .done_o      (done[0])
  );

  npu_act_norm u_big (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start[1]),
    .act_mode_i  (mode[1]),
    .leak_shift_i(lsh[1]),
    .in_valid_i  (in_valid[1]),
    .in_ready_o  (in_ready[1]),
    .in_data_i   (in_data[1]),
    .out_valid_o (out_valid[1]),
    .out_ready_i (out_ready[1]),
    .out_data_o  (out_data[1]),
    .busy_o      (busy[1]),
    .done_o      (done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nelem(input int k);
    return (k == 0) ? 4 : 100;
  endfunction

  task automatic push(input int k, input logic [7:0] v);
    if (k == 0) exp0.push_back(v);
    else exp1.push_back(v);
  endtask

  // Out-ready driver: 0 = held low, 1 = held high, otherwise random.
  initial begin
    out_ready = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        case (rdy_mode[k])
          0:       out_ready[k] = 1'b0;
          1:       out_ready[k] = 1'b1;
          default: out_ready[k] = ($urandom_range(0, 1) == 1);
        endcase
      end
    end
  end

  // Monitor: scoreboard pops, hold stability, first-output latency, done pulses.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        int sz;
        logic [7:0] e;
        if (!rst_n) begin
          hold_prev[k] = 1'b0;
          continue;
        end
        if (hold_prev[k]) begin
          chk("hold_valid", 32'(out_valid[k]), 32'd1);
          chk("hold_data", 32'(out_data[k]), 32'(hold_data[k]));
        end
        if (out_valid[k] && !first_seen[k]) begin
          first_seen[k] = 1'b1;
          chk("first_out_latency", 32'(cyc - last_in[k]), 32'(QW + 2));
        end
        if (out_valid[k] && out_ready[k]) begin
          sz = (k == 0) ? exp0.size() : exp1.size();
          if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL extra_output: got %0d on inst %0d, expected no output", out_data[k], k);
          end else begin
            e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
            chk("out_data", 32'(out_data[k]), 32'(e));
          end
        end
        hold_prev[k] = out_valid[k] && !out_ready[k];
        hold_data[k] = out_data[k];
        if (done[k]) done_cnt[k]++;
      end
    end
  end

  // Issue start and stream n elements of vec; optional random gaps and a start poke mid-load.
  task automatic run_in(input int k, input logic [1:0] m, input logic [3:0] sh, input int n,
                        input bit gaps, input bit poke);
    int w;
    bit s;
    @(posedge clk);
    #1;
    mode[k]       = m;
    lsh[k]        = sh;
    start[k]      = 1'b1;
    first_seen[k] = 1'b0;
    done_cnt[k]   = 0;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    mode[k]  = ~m;
    lsh[k]   = ~sh;
    chk("in_ready_rise", 32'(in_ready[k]), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          in_valid[k] = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid[k] = 1'b1;
      in_data[k]  = vec[i];
      if (poke && i == 1) start[k] = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        s = in_ready[k];
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        w++;
      end while (!s && w < 64);
      if (!s) begin
        chk("in_handshake_timeout", 32'(s), 32'd1);
        break;
      end
      last_in[k] = cyc;
    end
    in_valid[k] = 1'b0;
    if (n == nelem(k)) chk("in_ready_fall", 32'(in_ready[k]), 32'd0);
  endtask

  task automatic wait_done(input int k);
    int w = 0;
    while (!done[k] && w < 4000) begin
      @(negedge clk);
      w++;
    end
    if (!done[k]) begin
      chk("done_timeout", 32'(done[k]), 32'd1);
    end else begin
      chk("busy_with_done", 32'(busy[k]), 32'd1);
      @(negedge clk);
      chk("done_cleared", 32'(done[k]), 32'd0);
      chk("busy_cleared", 32'(busy[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    chk("done_pulses", 32'(done_cnt[k]), 32'd1);
    chk("sb_drained", 32'((k == 0) ? exp0.size() : exp1.size()), 32'd0);
  endtask

  task automatic wait_valid(input int k);
    int w = 0;
    while (!out_valid[k] && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("out_valid_seen", 32'(out_valid[k]), 32'd1);
  endtask

  // Bypass reference: integer min-max scaling over vec[0..n-1].
  task automatic push_model(input int k, input int n);
    longint mn, mx, r, sc, d, o;
    mn = vec[0];
    mx = vec[0];
    for (int i = 1; i < n; i++) begin
      if (vec[i] < mn) mn = vec[i];
      if (vec[i] > mx) mx = vec[i];
    end
    r  = mx - mn;
    sc = (r == 0) ? 0 : ((longint'(255) << Frac) / r);
    for (int i = 0; i < n; i++) begin
      d = longint'(vec[i]) - mn;
      o = (d * sc + (RoundEn ? (longint'(1) << (Frac - 1)) : 0)) >>> Frac;
      if (o > 255) o = 255;
      push(k, 8'(o));
    end
  endtask

  task automatic set4(input int a, input int b, input int c, input int d);
    vec[0] = 16'(a);
    vec[1] = 16'(b);
    vec[2] = 16'(c);
    vec[3] = 16'(d);
  endtask

  task automatic check_reset_outputs(input int k);
    chk("rst_in_ready", 32'(in_ready[k]), 32'd0);
    chk("rst_out_valid", 32'(out_valid[k]), 32'd0);
    chk("rst_out_data", 32'(out_data[k]), 32'd0);
    chk("rst_busy", 32'(busy[k]), 32'd0);
    chk("rst_done", 32'(done[k]), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = '0;
    in_valid   = '0;
    mode       = '0;
    lsh        = '0;
    in_data    = '0;
    rdy_mode   = '{1, 1};
    first_seen = '{1'b1, 1'b1};
    done_cnt   = '{0, 0};
    hold_prev  = '{1'b0, 1'b0};
    last_in    = '{0, 0};
    #2;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    rst_n = 1'b1;

    // ReLU on {-4,0,4,8}: a={0,0,4,8}, R=8, SCALE=2088960.
    set4(-4, 0, 4, 8);
    push(0, 8'd0); push(0, 8'd0); push(0, RoundEn ? 8'd128 : 8'd127); push(0, 8'd255);
    run_in(0, 2'b01, 4'd0, 4, 1'b0, 1'b0);
    wait_done(0);

    // Leaky, shift 2: a={-1,0,4,8}, R=9, SCALE=1856853.
    push(0, 8'd0); push(0, 8'd28);
    push(0, RoundEn ? 8'd142 : 8'd141); push(0, RoundEn ? 8'd255 : 8'd254);
    run_in(0, 2'b10, 4'd2, 4, 1'b0, 1'b0);
    wait_done(0);

    // Flat matrix: R=0 gives all zeros.
    set4(77, 77, 77, 77);
    for (int i = 0; i < 4; i++) push(0, 8'd0);
    run_in(0, 2'b10, 4'd3, 4, 1'b0, 1'b0);
    wait_done(0);
    for (int i = 0; i < 100; i++) vec[i] = 16'sd77;
    for (int i = 0; i < 100; i++) push(1, 8'd0);
    run_in(1, 2'b00, 4'd0, 100, 1'b0, 1'b0);
    wait_done(1);

    // 10x10 bypass with random input gaps and random out_ready.
    for (int i = 0; i < 100; i++) vec[i] = 16'(((i * 7919) % 6007) - 3000);
    push_model(1, 100);
    rdy_mode[1] = 2;
    run_in(1, 2'b00, 4'd0, 100, 1'b1, 1'b0);
    wait_done(1);

    // in_valid while idle must be ignored.
    in_valid[0] = 1'b1;
    in_data[0]  = 16'sd5;
    repeat (4) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready[0]), 32'd0);
      chk("idle_busy", 32'(busy[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;

    // start poked during LOAD and EMIT, in_valid during EMIT: all ignored.
    set4(-4, 0, 4, 8);
    push(0, 8'd0); push(0, 8'd0); push(0, RoundEn ? 8'd128 : 8'd127); push(0, 8'd255);
    rdy_mode[0] = 0;
    run_in(0, 2'b01, 4'd0, 4, 1'b0, 1'b1);
    wait_valid(0);
    @(posedge clk);
    #1;
    start[0]    = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0]  = 16'sd1234;
    @(posedge clk);
    #1;
    start[0]    = 1'b0;
    in_valid[0] = 1'b0;
    chk("emit_poke_busy", 32'(busy[0]), 32'd1);
    chk("emit_poke_in_ready", 32'(in_ready[0]), 32'd0);
    rdy_mode[0] = 1;
    wait_done(0);

    // Reset mid-LOAD on the 10x10 instance, then a clean job.
    for (int i = 0; i < 100; i++) vec[i] = 16'(((i * i * 37) % 20000) - 15000);
    rdy_mode[1] = 1;
    run_in(1, 2'b00, 4'd0, 30, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(1);
    exp1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    push_model(1, 100);
    rdy_mode[1] = 2;
    run_in(1, 2'b00, 4'd0, 100, 1'b0, 1'b0);
    wait_done(1);

    // Reset mid-EMIT while the first output (255) is held, then a clean job.
    set4(8, 4, 0, -4);
    rdy_mode[0] = 0;
    run_in(0, 2'b01, 4'd0, 4, 1'b0, 1'b0);
    wait_valid(0);
    chk("held_before_reset", 32'(out_data[0]), 32'd255);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    exp0.delete();
    rdy_mode[0] = 1;
    @(negedge clk);
    rst_n = 1'b1;
    set4(-4, 0, 4, 8);
    push(0, 8'd0); push(0, 8'd0); push(0, RoundEn ? 8'd128 : 8'd127); push(0, 8'd255);
    run_in(0, 2'b01, 4'd0, 4, 1'b0, 1'b0);
    wait_done(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/npu_act_norm.md
# npu_act_norm

Parametrised activation and normalisation stage for the NPU datapath, placed between the systolic array result stream and the 8-bit output store. It accepts a ROWS×COLS signed matrix as a row-major valid/ready stream and applies a run-time-selected activation: bypass, ReLU or leaky ReLU with programmable shift. It buffers the activated matrix and tracks its min and max. It then emits every element min-max normalised to OUT_W unsigned bits through an exact sequentially computed fixed-point scale.

## Interface
- ROWS, 10, matrix rows
- COLS, 10, matrix columns; N = ROWS*COLS elements per job
- IN_W, 16, signed input element width
- OUT_W, 8, unsigned output width; full scale M = 2^OUT_W-1
- FRAC, 16, fraction bits of scale; QW = OUT_W+FRAC

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle job request, sampled only in IDLE
- act_mode  in  2  00 bypass, 01 ReLU, 10 leaky, 11 bypass; latched at start
- leak_shift  in  4  leaky slope 2^-leak_shift; latched at start
- in_valid  in  1  input element valid
- in_ready  out  1  high only in LOAD
- in_data  in  IN_W  signed element, row-major
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_W  normalised element
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last output handshake

## Operation
- FSM: IDLE -> LOAD (start) -> DIV (N-th input handshake) -> PRIME (QW cycles) -> EMIT (1 cycle) -> DONE (N-th output handshake) -> IDLE (1 cycle, done=1).
- Activation per accepted element: bypass a=x; ReLU a=max(x,0); leaky a = x>=0 ? x : x>>>leak_shift, arithmetic shift, floor. Result stays IN_W signed.
- LOAD: write a to buffer[idx]; idx counts 0..N-1. Running min/max are initialised from element 0.
- DIV: range R = max-min, unsigned IN_W. Restoring divider produces one quotient bit per cycle, giving SCALE = floor((M<<FRAC)/R) on QW bits. R==0 forces SCALE=0.
- PRIME: registered buffer read of element 0.
- EMIT: out_data = min(((a-min)*SCALE + RND)>>FRAC, M), with product width IN_W+QW and RND per Configuration. Hold out_valid/out_data while out_ready is low. Advance by one element per handshake. Back-to-back handshakes must sustain 1 element/cycle.
- start outside IDLE is ignored. in_valid outside LOAD is ignored and no data is consumed.
- Reset mid-job aborts the job. Buffer contents are don't-care. Next job starts clean.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, state IDLE, counters 0.
- in_ready rises the cycle after start is sampled.
- in_ready falls the cycle after the N-th input handshake.
- First out_valid rises QW+2 cycles after the N-th input handshake edge.
- With out_ready held high, the job takes N output cycles.
- done is asserted 1 cycle after the N-th output handshake.
- busy falls together with done.
- A new start is accepted the cycle after done.

## Configuration
- NPU_ACT_NORM_ROUND_EN defined: RND = 2^(FRAC-1), round-half-up before the shift. Result is still clamped to M.
- Not defined: RND = 0, truncation.

## Test plan
- ROWS=COLS=2, ReLU, in {-4,0,4,8}. Required out {0,0,127,255}, or {0,0,128,255} with ROUND_EN. done pulses once.
- Same inputs, leaky, leak_shift=2, giving a={-1,0,4,8}, R=9, SCALE=1856853. Required out {0,28,141,254}, or {0,28,142,255} with ROUND_EN.
- All elements equal 77, any mode. Required: all outputs 0, no X, done asserted.
- Default 10×10, bypass, random in_valid and out_ready toggling. Outputs must match a reference model. out_data must stay stable while out_valid && !out_ready. First out_valid must come exactly QW+2 cycles after the last input.
- rst_n low mid-LOAD and again mid-EMIT. Required: outputs return to reset values immediately. A following clean job must produce correct results.
- start pulsed during LOAD/EMIT, and in_valid driven during IDLE/EMIT. Required: no state change, no extra data consumed, a single done per job.
